// File: rtl/uart_trig_pkg.sv
// Shared types and constants for the UART frame trigger controller.
package uart_trig_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int BAUD_W_DEF   = 16;
   localparam int MIN_BAUD_DEF = 4;

   // Frame bit positions: start = 0, data = 1..DATA_W, stop = DATA_W + 1.
   localparam int STOP_IDX = DATA_W_DEF + 1;

   function automatic int stop_idx(input int data_w);
      return data_w + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer; expire is high while the count sits at zero.
module uart_bit_timer #(
   parameter int BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BAUD_W-1:0] load_val,
   output logic              expire
);

   logic [BAUD_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - BAUD_W'(1);
      end
   end

   assign expire = (r_cnt == '0);

endmodule

// File: rtl/uart_trig_ctrl.sv
// UART receiver that pulses a trigger on valid frames whose payload matches
// match under mask. o_state exposes the FSM state for observation.
module uart_trig_ctrl
   import uart_trig_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int BAUD_W   = BAUD_W_DEF,
   parameter int MIN_BAUD = MIN_BAUD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RX,
   input  logic [BAUD_W-1:0] baud_cnt,
   input  logic [DATA_W-1:0] mask,
   input  logic [DATA_W-1:0] match,
   input  logic              arm,
   output logic              UARTtrig,
   output logic              rdy,
   output logic              frame_err,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic [1:0]        o_state
);

   localparam int CNT_W    = $clog2(DATA_W + 1);
   localparam int LAST_BIT = stop_idx(DATA_W) - 2;

   state_t              r_state;
   state_t              w_next;
   logic                r_rx_meta;
   logic                r_rx_sync;
   logic                r_rx_prev;
   logic [BAUD_W-1:0]   r_baud_q;
   logic [DATA_W-1:0]   r_shift;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_rdy;
   logic                r_trig;
   logic                r_ferr;
   logic [DATA_W-1:0]   r_rx_data;

   logic                w_expire;
   logic                w_load;
   logic [BAUD_W-1:0]   w_load_val;
   logic [BAUD_W-1:0]   w_baud_eff;
   logic                w_latch_baud;
   logic                w_shift_en;
   logic                w_clr_cnt;
   logic                w_frame_ok;
   logic                w_frame_bad;
   logic                w_hit;

   uart_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (w_load_val),
      .expire   (w_expire)
   );

   assign w_baud_eff = (baud_cnt < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : baud_cnt;
   assign w_hit      = ((r_shift | mask) == (match | mask));

   always_comb begin
      w_next       = r_state;
      w_load       = 1'b0;
      w_load_val   = '0;
      w_latch_baud = 1'b0;
      w_shift_en   = 1'b0;
      w_clr_cnt    = 1'b0;
      w_frame_ok   = 1'b0;
      w_frame_bad  = 1'b0;
      case (r_state)
         IDLE: begin
            if (arm && r_rx_prev && !r_rx_sync) begin
               w_next       = START;
               w_latch_baud = 1'b1;
               w_load       = 1'b1;
               w_load_val   = (w_baud_eff >> 1) - BAUD_W'(1);
            end
         end
         START: begin
            if (w_expire) begin
               if (r_rx_sync) begin
                  w_next = IDLE;
               end else begin
                  // Start check lands one cycle before H, so the first data
                  // period is a full baud_q to keep samples at H + k*baud_q.
                  w_next     = DATA;
                  w_load     = 1'b1;
                  w_load_val = r_baud_q;
                  w_clr_cnt  = 1'b1;
               end
            end
         end
         DATA: begin
            if (w_expire) begin
               w_shift_en = 1'b1;
               w_load     = 1'b1;
               w_load_val = r_baud_q - BAUD_W'(1);
               if (r_bit_cnt == CNT_W'(LAST_BIT)) begin
                  w_next = STOP;
               end
            end
         end
         STOP: begin
            if (w_expire) begin
               w_next      = IDLE;
               w_frame_ok  = r_rx_sync;
               w_frame_bad = !r_rx_sync;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
         r_baud_q  <= BAUD_W'(MIN_BAUD);
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_rdy     <= 1'b0;
         r_trig    <= 1'b0;
         r_ferr    <= 1'b0;
         r_rx_data <= '0;
      end else begin
         r_rx_meta <= RX;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
         if (w_latch_baud) begin
            r_baud_q <= w_baud_eff;
         end
         if (w_clr_cnt) begin
            r_bit_cnt <= '0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
         if (w_shift_en) begin
            r_shift <= {r_rx_sync, r_shift[DATA_W-1:1]};
         end
         r_rdy  <= w_frame_ok;
         r_trig <= w_frame_ok && arm && w_hit;
         r_ferr <= w_frame_bad;
         if (w_frame_ok) begin
            r_rx_data <= r_shift;
         end
      end
   end

   assign UARTtrig  = r_trig;
   assign rdy       = r_rdy;
   assign frame_err = r_ferr;
   assign rx_data   = r_rx_data;
   assign busy      = (r_state != IDLE);
   assign o_state   = r_state;

endmodule

// File: tb/tb_uart_trig_ctrl.sv
// Bench for uart_trig_ctrl: frame driver, timing/value model, queue scoreboard.
module tb_uart_trig_ctrl;
   import uart_trig_pkg::*;

   localparam int DW    = DATA_W_DEF;
   localparam int BW    = BAUD_W_DEF;
   localparam int EXP_W = 32 + 3 + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          RX;
   logic [BW-1:0] baud_cnt;
   logic [DW-1:0] mask;
   logic [DW-1:0] match;
   logic          arm;
   logic          UARTtrig;
   logic          rdy;
   logic          frame_err;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic [1:0]    dut_state;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int busy_cnt = 0;

   // Each entry: {cycle, rdy, trig, frame_err, rx_data}
   logic [EXP_W-1:0] exp_q[$];
   logic [DW-1:0]    model_data = '0;

   uart_trig_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .baud_cnt  (baud_cnt),
      .mask      (mask),
      .match     (match),
      .arm       (arm),
      .UARTtrig  (UARTtrig),
      .rdy       (rdy),
      .frame_err (frame_err),
      .rx_data   (rx_data),
      .busy      (busy),
      .o_state   (dut_state)
   );

   // Clock / reset timebase
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got cycle %0d required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: pops one expectation per output event
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!rst) begin
         if (busy) busy_cnt++;
         if (rdy || frame_err || UARTtrig) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 64'({rdy, UARTtrig, frame_err}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("event_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
               check("rdy", 64'(rdy), 64'(e[DW+2]));
               check("UARTtrig", 64'(UARTtrig), 64'(e[DW+1]));
               check("frame_err", 64'(frame_err), 64'(e[DW]));
               check("rx_data", 64'(rx_data), 64'(e[DW-1:0]));
               check("busy_at_event", 64'(busy), 64'd0);
            end
         end
      end
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      RX = 1'b1;
      repeat (n) step();
   endtask

   // act_code 1: baud_cnt -> 32 at T0+40; act_code 2: arm -> 0 at T0+40.
   // abort_at != 0: pulse rst at that offset (T0 + abort_at - 3).
   task automatic drive_frame(input logic [DW-1:0] data, input logic stop_bit,
                              input int act_code, input int abort_at, input int tail);
      int             eff;
      int             h;
      int             c;
      logic [DW+1:0]  bits;
      logic           trig;
      eff  = (int'(baud_cnt) < MIN_BAUD_DEF) ? MIN_BAUD_DEF : int'(baud_cnt);
      h    = eff / 2;
      bits = {stop_bit, data, 1'b0};
      c    = cyc;
      // T0 = c + 3 (two sync flops plus edge register); outputs one cycle after the stop sample
      if (arm && abort_at == 0) begin
         if (stop_bit) begin
            trig       = (act_code != 2) && ((data | mask) == (match | mask));
            model_data = data;
            exp_q.push_back({32'(c + 3 + h + 9 * eff + 1), 1'b1, trig, 1'b0, data});
         end else begin
            exp_q.push_back({32'(c + 3 + h + 9 * eff + 1), 1'b0, 1'b0, 1'b1, model_data});
         end
      end
      for (int n = 0; n < (DW + 2) * eff; n++) begin
         RX = bits[n / eff];
         if (n == 43) begin
            if (act_code == 1) baud_cnt = BW'(32);
            if (act_code == 2) arm = 1'b0;
         end
         if (abort_at != 0 && n == abort_at) begin
            check("busy_before_reset", 64'(busy), 64'd1);
            #2 rst = 1'b1;
            #1;
            check("rst_rdy", 64'(rdy), 64'd0);
            check("rst_trig", 64'(UARTtrig), 64'd0);
            check("rst_frame_err", 64'(frame_err), 64'd0);
            check("rst_rx_data", 64'(rx_data), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_state", 64'(dut_state), 64'(IDLE));
            model_data = '0;
            RX = 1'b1;
            step();
            step();
            #3 rst = 1'b0;
            return;
         end
         step();
      end
      repeat (tail) step();
      idle_cycles(6);
   endtask

   // Stimulus
   initial begin
      logic [DW-1:0] d;
      logic          sb;
      int            b0;
      rst      = 1'b1;
      RX       = 1'b1;
      baud_cnt = BW'(16);
      mask     = '0;
      match    = '0;
      arm      = 1'b0;
      repeat (3) step();
      check("reset_rdy", 64'(rdy), 64'd0);
      check("reset_trig", 64'(UARTtrig), 64'd0);
      check("reset_frame_err", 64'(frame_err), 64'd0);
      check("reset_rx_data", 64'(rx_data), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_state", 64'(dut_state), 64'(IDLE));
      #2 rst = 1'b0;
      idle_cycles(5);

      // Exact match, then masked match / mismatch
      arm   = 1'b1;
      match = 8'hA5;
      drive_frame(8'hA5, 1'b1, 0, 0, 2);
      mask  = 8'h0F;
      match = 8'hA0;
      drive_frame(8'hA7, 1'b1, 0, 0, 2);
      drive_frame(8'hB7, 1'b1, 0, 0, 2);

      // Short low glitch rejected in START
      b0 = busy_cnt;
      RX = 1'b0;
      repeat (3) step();
      RX = 1'b1;
      repeat (30) step();
      check("false_start_busy_cycles", 64'(busy_cnt - b0), 64'd8);
      check("false_start_state", 64'(dut_state), 64'(IDLE));

      // Bad stop bit followed by a long break, then a clean frame
      mask  = 8'h00;
      match = 8'h3C;
      drive_frame(8'h3C, 1'b0, 0, 0, 60);
      drive_frame(8'h3C, 1'b1, 0, 0, 2);

      // Reset in the middle of a frame, then a clean frame
      drive_frame(8'h55, 1'b1, 0, 63, 0);
      idle_cycles(10);
      drive_frame(8'h55, 1'b1, 0, 0, 2);

      // Disarmed: nothing happens
      arm   = 1'b0;
      match = 8'hA5;
      b0    = busy_cnt;
      drive_frame(8'hA5, 1'b1, 0, 0, 2);
      check("disarmed_busy_cycles", 64'(busy_cnt - b0), 64'd0);

      // Disarm mid-frame: rdy without trigger
      arm = 1'b1;
      drive_frame(8'hA5, 1'b1, 2, 0, 2);
      arm = 1'b1;

      // Baud change mid-frame applies to the next frame
      baud_cnt = BW'(16);
      match    = 8'hC3;
      drive_frame(8'h5A, 1'b1, 1, 0, 2);
      drive_frame(8'hC3, 1'b1, 0, 0, 2);

      // Below-minimum baud behaves as MIN_BAUD
      baud_cnt = BW'(1);
      match    = 8'h81;
      drive_frame(8'h81, 1'b1, 0, 0, 2);
      drive_frame(8'h7E, 1'b1, 0, 0, 2);

      // Randomized frames
      for (int i = 0; i < 30; i++) begin
         baud_cnt = BW'($urandom_range(0, 24));
         mask     = DW'($urandom);
         match    = DW'($urandom);
         arm      = ($urandom_range(0, 9) != 0);
         d        = DW'($urandom);
         if ($urandom_range(0, 2) == 0) d = (match & ~mask) | (d & mask);
         sb       = ($urandom_range(0, 6) != 0);
         drive_frame(d, sb, 0, 0, $urandom_range(2, 8));
      end

      arm = 1'b1;
      idle_cycles(40);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
